// File: rtl/traffic_light_ctrl_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_pkg
// Description : Shared types and encodings for the N-direction traffic light
//               controller: per-direction light codes and controller phases.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_pkg;

    localparam int c_LIGHT_W = 2;
    localparam int c_PHASE_W = 2;

    typedef enum logic [c_LIGHT_W-1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        OFF    = 2'b11
    } light_t;

    typedef enum logic [c_PHASE_W-1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_FLASH  = 2'b11
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/traffic_light_ctrl_n_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : tl_rr_pick
// Description : Combinational round-robin chooser. Returns the first asserted
//               request found when searching from i_base upwards, wrapping
//               around through all NUM_DIR entries.
// Ports       : i_req   - request vector, one bit per direction
//               i_base  - index where the search starts (highest priority)
//               o_grant - selected index (i_base when nothing is requested)
//               o_valid - at least one request was found
// Revision    : 1.0 - initial release
// ============================================================================
module tl_rr_pick #(
    parameter  int NUM_DIR = 4,
    localparam int IDX_W   = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] i_req,
    input  logic [IDX_W-1:0]   i_base,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_valid
);

    int w_idx;

    // Scan from the far end back towards i_base so the nearest request wins.
    always_comb begin
        o_grant = i_base;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = NUM_DIR - 1; k >= 0; k--) begin
            w_idx = (int'(i_base) + k) % NUM_DIR;
            if (i_req[IDX_W'(w_idx)]) begin
                o_grant = IDX_W'(w_idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl_n
// Description : N-direction intersection controller. Green with min/max dwell,
//               timed yellow, all-red clearance, round-robin skipping of idle
//               directions and a night flashing-yellow mode. All dwell times
//               are counted in tick pulses.
// Ports       : clk, reset (async, active-high), tick (timing strobe),
//               sensor[NUM_DIR] (vehicle present), flash_mode (flash request),
//               lights[2*NUM_DIR] (2-bit code per direction), active_dir,
//               phase
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl_n
    import traffic_light_pkg::*;
#(
    parameter  int NUM_DIR    = 4,
    parameter  int CNT_W      = 8,
    parameter  int MIN_GREEN  = 8,
    parameter  int MAX_GREEN  = 32,
    parameter  int YELLOW_T   = 4,
    parameter  int ALLRED_T   = 2,
    parameter  int FLASH_HALF = 4,
    localparam int IDX_W      = $clog2(NUM_DIR)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [NUM_DIR-1:0]     sensor,
    input  logic                   flash_mode,
    output logic [2*NUM_DIR-1:0]   lights,
    output logic [IDX_W-1:0]       active_dir,
    output logic [1:0]             phase
);

    // Dwell count is one bit wider than the timer so timer+1 never wraps.
    localparam logic [CNT_W:0] c_MIN_G  = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] c_MAX_G  = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] c_YEL    = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0] c_ALLRED = (CNT_W+1)'(ALLRED_T);
    localparam logic [CNT_W:0] c_FLASH  = (CNT_W+1)'(FLASH_HALF);

    phase_t             r_phase;
    logic [IDX_W-1:0]   r_active;
    logic [IDX_W-1:0]   r_next;
    logic [CNT_W-1:0]   r_timer;
    logic               r_flash_on;

    logic [CNT_W:0]     w_cnt;
    logic [CNT_W-1:0]   w_timer_inc;
    logic [IDX_W-1:0]   w_base;
    logic [NUM_DIR-1:0] w_own_mask;
    logic               w_others_req;
    logic               w_green_exit;
    logic [IDX_W-1:0]   w_grant;
    logic               w_grant_vld;

    assign w_cnt       = {1'b0, r_timer} + 1'b1;
    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;
    assign w_base      = (r_active == IDX_W'(NUM_DIR - 1)) ? '0 : r_active + 1'b1;

    always_comb begin
        w_own_mask           = '0;
        w_own_mask[r_active] = 1'b1;
    end

    assign w_others_req = |(sensor & ~w_own_mask);

    assign w_green_exit = (w_cnt >= c_MIN_G) &&
                          (flash_mode ||
                           (w_others_req && (!sensor[r_active] || (w_cnt >= c_MAX_G))));

    // Search starts one past the current owner, so the owner itself is the
    // last candidate and idle directions are skipped.
    tl_rr_pick #(
        .NUM_DIR (NUM_DIR)
    ) u_rr_pick (
        .i_req   (sensor),
        .i_base  (w_base),
        .o_grant (w_grant),
        .o_valid (w_grant_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase    <= PH_ALLRED;
            r_active   <= '0;
            r_next     <= '0;
            r_timer    <= '0;
            r_flash_on <= 1'b0;
        end else if (tick) begin
            case (r_phase)
                PH_GREEN: begin
                    if (w_green_exit) begin
                        r_phase <= PH_YELLOW;
                        r_timer <= '0;
                        r_next  <= w_grant_vld ? w_grant : r_active;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                PH_YELLOW: begin
                    if (w_cnt == c_YEL) begin
                        r_phase <= PH_ALLRED;
                        r_timer <= '0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                PH_ALLRED: begin
                    if (w_cnt == c_ALLRED) begin
                        r_timer <= '0;
                        if (flash_mode) begin
                            r_phase    <= PH_FLASH;
                            r_flash_on <= 1'b1;
                        end else begin
                            r_phase  <= PH_GREEN;
                            r_active <= r_next;
                        end
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                PH_FLASH: begin
                    if (!flash_mode) begin
                        // Leaving flash resumes green on the same direction.
                        r_phase    <= PH_ALLRED;
                        r_timer    <= '0;
                        r_next     <= r_active;
                        r_flash_on <= 1'b0;
                    end else if (w_cnt == c_FLASH) begin
                        r_flash_on <= ~r_flash_on;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_phase <= PH_ALLRED;
                    r_timer <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar d = 0; d < NUM_DIR; d++) begin : g_lights
            light_t w_light;
            always_comb begin
                w_light = RED;
                case (r_phase)
                    PH_GREEN:  w_light = (r_active == IDX_W'(d)) ? GREEN  : RED;
                    PH_YELLOW: w_light = (r_active == IDX_W'(d)) ? YELLOW : RED;
                    PH_ALLRED: w_light = RED;
                    PH_FLASH:  w_light = r_flash_on ? YELLOW : OFF;
                    default:   w_light = RED;
                endcase
            end
            assign lights[2*d +: 2] = w_light;
        end
    endgenerate

    assign active_dir = r_active;
    assign phase      = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl_n
// Description : Self-checking bench for traffic_light_ctrl_n (4 directions,
//               short timing). Vector tables hold per-cycle inputs and the
//               outputs expected after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] sensor = '0;
    logic       flash_mode = 1'b0;
    logic [7:0] lights;
    logic [1:0] active_dir;
    logic [1:0] phase;

    traffic_light_ctrl_n #(
        .NUM_DIR    (4),
        .CNT_W      (8),
        .MIN_GREEN  (3),
        .MAX_GREEN  (6),
        .YELLOW_T   (2),
        .ALLRED_T   (1),
        .FLASH_HALF (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .sensor     (sensor),
        .flash_mode (flash_mode),
        .lights     (lights),
        .active_dir (active_dir),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic [3:0] sen;
        logic       fl;
        logic [7:0] lights;
        logic [1:0] ph;
        logic [1:0] dir;
    } vec_t;

    typedef struct {
        logic [7:0] lights;
        logic [1:0] ph;
        logic [1:0] dir;
        int         id;
    } exp_t;

    localparam logic [1:0] G = 2'd0, Y = 2'd1, AR = 2'd2, FL = 2'd3;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rec_id = 0;
    logic [7:0] last_l;
    logic [1:0] last_p;
    logic [1:0] last_d;

    task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h expected %h", nm, id, got, want);
        end
    endtask

    task automatic add(input int n, input logic tk, input logic [3:0] sen, input logic fl,
                       input logic [7:0] l, input logic [1:0] p, input logic [1:0] d);
        for (int i = 0; i < n; i++) tbl.push_back('{tk, sen, fl, l, p, d});
        last_l = l; last_p = p; last_d = d;
    endtask

    // One tick every third cycle: two frozen cycles, then the ticking one.
    task automatic add_slow(input int n, input logic [3:0] sen, input logic fl,
                            input logic [7:0] l, input logic [1:0] p, input logic [1:0] d);
        for (int i = 0; i < n; i++) begin
            add(2, 1'b0, sen, fl, last_l, last_p, last_d);
            add(1, 1'b1, sen, fl, l, p, d);
        end
    endtask

    task automatic check_now(input string tag, input logic [7:0] l, input logic [1:0] p, input logic [1:0] d);
        exp_t e;
        sb.push_back('{l, p, d, rec_id});
        e = sb.pop_front();
        chk({tag, "_lights"}, e.id, lights, e.lights);
        chk({tag, "_phase"}, e.id, 8'(phase), 8'(e.ph));
        chk({tag, "_dir"}, e.id, 8'(active_dir), 8'(e.dir));
    endtask

    task automatic run_table();
        exp_t e;
        foreach (tbl[i]) begin
            tick       = tbl[i].tk;
            sensor     = tbl[i].sen;
            flash_mode = tbl[i].fl;
            sb.push_back('{tbl[i].lights, tbl[i].ph, tbl[i].dir, rec_id});
            rec_id++;
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("lights", e.id, lights, e.lights);
            chk("phase", e.id, 8'(phase), 8'(e.ph));
            chk("active_dir", e.id, 8'(active_dir), 8'(e.dir));
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; sensor = '0; flash_mode = 1'b0;
        @(posedge clk);
        #1;
        check_now("in_reset", 8'hAA, AR, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_now("post_reset", 8'hAA, AR, 2'd0);
        last_l = 8'hAA; last_p = AR; last_d = 2'd0;
    endtask

    initial begin
        // Idle intersection: dir0 takes green and keeps it.
        do_reset();
        add(21, 1'b1, 4'b0000, 1'b0, 8'hA8, G, 2'd0);
        run_table();

        // Single request on dir2: dir1 is skipped.
        do_reset();
        add(1, 1'b1, 4'b0000, 1'b0, 8'hA8, G, 2'd0);
        add(2, 1'b1, 4'b0100, 1'b0, 8'hA8, G, 2'd0);
        add(2, 1'b1, 4'b0100, 1'b0, 8'hA9, Y, 2'd0);
        add(1, 1'b1, 4'b0100, 1'b0, 8'hAA, AR, 2'd0);
        add(3, 1'b1, 4'b0100, 1'b0, 8'h8A, G, 2'd2);
        run_table();

        // Constant demand on 0,1,3: each green runs to MAX_GREEN.
        do_reset();
        add(6, 1'b1, 4'b1011, 1'b0, 8'hA8, G, 2'd0);
        add(2, 1'b1, 4'b1011, 1'b0, 8'hA9, Y, 2'd0);
        add(1, 1'b1, 4'b1011, 1'b0, 8'hAA, AR, 2'd0);
        add(6, 1'b1, 4'b1011, 1'b0, 8'hA2, G, 2'd1);
        add(2, 1'b1, 4'b1011, 1'b0, 8'hA6, Y, 2'd1);
        add(1, 1'b1, 4'b1011, 1'b0, 8'hAA, AR, 2'd1);
        add(6, 1'b1, 4'b1011, 1'b0, 8'h2A, G, 2'd3);
        add(2, 1'b1, 4'b1011, 1'b0, 8'h6A, Y, 2'd3);
        add(1, 1'b1, 4'b1011, 1'b0, 8'hAA, AR, 2'd3);
        add(2, 1'b1, 4'b1011, 1'b0, 8'hA8, G, 2'd0);
        run_table();

        // Same as the dir2 case with tick every third cycle.
        do_reset();
        add(1, 1'b1, 4'b0000, 1'b0, 8'hA8, G, 2'd0);
        add_slow(2, 4'b0100, 1'b0, 8'hA8, G, 2'd0);
        add_slow(2, 4'b0100, 1'b0, 8'hA9, Y, 2'd0);
        add_slow(1, 4'b0100, 1'b0, 8'hAA, AR, 2'd0);
        add_slow(2, 4'b0100, 1'b0, 8'h8A, G, 2'd2);
        run_table();

        // Flash mode entry, blinking, and exit back to dir0 green.
        do_reset();
        add(1, 1'b1, 4'b0000, 1'b0, 8'hA8, G, 2'd0);
        add(2, 1'b1, 4'b0000, 1'b1, 8'hA8, G, 2'd0);
        add(2, 1'b1, 4'b0000, 1'b1, 8'hA9, Y, 2'd0);
        add(1, 1'b1, 4'b0000, 1'b1, 8'hAA, AR, 2'd0);
        add(2, 1'b1, 4'b0000, 1'b1, 8'h55, FL, 2'd0);
        add(2, 1'b1, 4'b0000, 1'b1, 8'hFF, FL, 2'd0);
        add(2, 1'b1, 4'b0000, 1'b1, 8'h55, FL, 2'd0);
        add(1, 1'b1, 4'b0000, 1'b0, 8'hAA, AR, 2'd0);
        add(3, 1'b1, 4'b0000, 1'b0, 8'hA8, G, 2'd0);
        run_table();

        // Drive to dir1 yellow, then assert reset between clock edges.
        do_reset();
        add(3, 1'b1, 4'b0010, 1'b0, 8'hA8, G, 2'd0);
        add(2, 1'b1, 4'b0010, 1'b0, 8'hA9, Y, 2'd0);
        add(1, 1'b1, 4'b0010, 1'b0, 8'hAA, AR, 2'd0);
        add(1, 1'b1, 4'b0010, 1'b0, 8'hA2, G, 2'd1);
        add(2, 1'b1, 4'b0001, 1'b0, 8'hA2, G, 2'd1);
        add(1, 1'b1, 4'b0001, 1'b0, 8'hA6, Y, 2'd1);
        run_table();
        #2;
        reset = 1'b1;
        #1;
        check_now("async_reset", 8'hAA, AR, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
